// File: rtl/cal_hu_hls_deadlock_report_ctrl.sv
// cal_hu_hls_deadlock_report_ctrl
// Central controller of the CAL_Hu deadlock-detection network. Picks the
// lowest-index detecting unit as origin, broadcasts the detection, follows
// the returning token to rebuild the dependency cycle and streams the
// ordered list of process IDs out through a small first-word-fall-through
// report FIFO.
module cal_hu_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM = 4,
  parameter int ID_W     = 2,
  parameter int TIMEOUT  = 1024,
  parameter int TO_W     = 11
) (
  input  logic                reset,
  input  logic                clock,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_vec,
  output logic                dl_detect_any,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [ID_W-1:0]     report_id,
  output logic                report_last,
  output logic                report_timeout,
  output logic                busy
);

  localparam int PW = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
  localparam int CW = $clog2(PROC_NUM + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     org_id;
  logic [PROC_NUM-1:0] visited;
  logic [PROC_NUM-1:0] pending;
  logic [TO_W-1:0]     to_cnt;

  // Report FIFO storage; depth equals the process count because visited
  // allows each process to be reported at most once per detection.
  logic [ID_W-1:0]     fifo_mem [PROC_NUM];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic                det_any;
  logic [ID_W-1:0]     det_idx;
  logic [PROC_NUM-1:0] det_onehot;
  logic [PROC_NUM-1:0] captured;
  logic [PROC_NUM-1:0] visited_nxt;
  logic [ID_W-1:0]     pend_idx;
  logic [PROC_NUM-1:0] pend_onehot;
  logic [PROC_NUM-1:0] pending_nxt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                idle_push;
  logic                drain_push;
  logic                push;
  logic [ID_W-1:0]     push_id;
  logic                pop;
  logic                timeout_hit;

  // Pick the lowest-index detecting unit as the cycle origin.
  always_comb begin
    det_idx    = '0;
    det_onehot = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (dl_detect_vec[i]) begin
        det_idx    = ID_W'(i);
        det_onehot = '0;
        det_onehot[i] = 1'b1;
      end
    end
  end

  // Merge newly arriving tokens into pending while walking; capture stops in DONE.
  always_comb begin
    captured    = pending;
    visited_nxt = visited;
    if (state == WALK) begin
      captured    = pending | (token_vec & ~visited);
      visited_nxt = visited | token_vec;
    end
  end

  // Select the lowest pending process as the next report entry.
  always_comb begin
    pend_idx    = '0;
    pend_onehot = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (captured[i]) begin
        pend_idx    = ID_W'(i);
        pend_onehot = '0;
        pend_onehot[i] = 1'b1;
      end
    end
  end

  // Push/pop arbitration and the cycle-closure / timeout conditions.
  always_comb begin
    det_any     = |dl_detect_vec;
    fifo_full   = (count == CW'(PROC_NUM));
    fifo_empty  = (count == '0);
    idle_push   = (state == IDLE) && det_any;
    drain_push  = (state != IDLE) && (|captured) && !fifo_full;
    push        = idle_push || drain_push;
    push_id     = idle_push ? det_idx : pend_idx;
    pop         = !fifo_empty && report_ready;
    pending_nxt = drain_push ? (captured & ~pend_onehot) : captured;
    token_clear = (state == WALK) && token_vec[org_id] && dl_detect_vec[org_id];
    timeout_hit = (state == WALK) && !token_clear && (to_cnt == TO_W'(TIMEOUT - 1));
  end

  // Controller FSM: origin selection, token walk, timeout and terminal state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      org_id         <= '0;
      visited        <= '0;
      pending        <= '0;
      to_cnt         <= '0;
      dl_detect_any  <= 1'b0;
      origin_vec     <= '0;
      report_timeout <= 1'b0;
    end else begin
      origin_vec <= '0;
      case (state)
        IDLE: begin
          if (det_any) begin
            state         <= WALK;
            org_id        <= det_idx;
            origin_vec    <= det_onehot;
            dl_detect_any <= 1'b1;
            visited       <= det_onehot;
            pending       <= '0;
            to_cnt        <= '0;
          end
        end
        WALK: begin
          visited <= visited_nxt;
          pending <= pending_nxt;
          to_cnt  <= to_cnt + TO_W'(1);
          if (token_clear) begin
            state <= DONE;
          end else if (timeout_hit) begin
            state          <= DONE;
            report_timeout <= 1'b1;
          end
        end
        DONE: begin
          pending <= pending_nxt;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Report FIFO: write on push, advance read pointer on valid & ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < PROC_NUM; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_id;
        wr_ptr <= (wr_ptr == PW'(PROC_NUM - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(PROC_NUM - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Report stream outputs; the last flag waits until nothing more can arrive.
  always_comb begin
    report_valid = !fifo_empty;
    report_id    = fifo_empty ? '0 : fifo_mem[rd_ptr];
    report_last  = report_valid && (state == DONE) && (pending == '0) &&
                   (count == CW'(1));
    busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_cal_hu_hls_deadlock_report_ctrl.sv
// tb_cal_hu_hls_deadlock_report_ctrl
// Directed bench for the deadlock report controller. Stimulus pushes the
// expected report entries into a queue; a separate monitor pops and
// compares whenever an entry is handed over on valid & ready.
module tb_cal_hu_hls_deadlock_report_ctrl;

  localparam int PROC_NUM = 4;
  localparam int ID_W     = 2;
  localparam int TIMEOUT  = 1024;
  localparam int TO_W     = 11;

  logic                reset;
  logic                clock;
  logic [PROC_NUM-1:0] dl_detect_vec;
  logic [PROC_NUM-1:0] token_vec;
  logic                dl_detect_any;
  logic [PROC_NUM-1:0] origin_vec;
  logic                token_clear;
  logic                report_valid;
  logic                report_ready;
  logic [ID_W-1:0]     report_id;
  logic                report_last;
  logic                report_timeout;
  logic                busy;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
  } entry_t;

  entry_t exp_q[$];
  int     total = 0;
  int     bad   = 0;

  cal_hu_hls_deadlock_report_ctrl #(
    .PROC_NUM(PROC_NUM),
    .ID_W(ID_W),
    .TIMEOUT(TIMEOUT),
    .TO_W(TO_W)
  ) dut (
    .reset(reset),
    .clock(clock),
    .dl_detect_vec(dl_detect_vec),
    .token_vec(token_vec),
    .dl_detect_any(dl_detect_any),
    .origin_vec(origin_vec),
    .token_clear(token_clear),
    .report_valid(report_valid),
    .report_ready(report_ready),
    .report_id(report_id),
    .report_last(report_last),
    .report_timeout(report_timeout),
    .busy(busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something never settles.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=still_running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [PROC_NUM-1:0] det,
                               input logic [PROC_NUM-1:0] tok,
                               input logic rdy);
    dl_detect_vec = det;
    token_vec     = tok;
    report_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expectEntry(input logic [ID_W-1:0] id, input logic last);
    entry_t e;
    e.id   = id;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_dl_detect_any"}, 32'(dl_detect_any), 32'd0);
    checkOutput({tag, "_origin_vec"}, 32'(origin_vec), 32'd0);
    checkOutput({tag, "_report_valid"}, 32'(report_valid), 32'd0);
    checkOutput({tag, "_report_last"}, 32'(report_last), 32'd0);
    checkOutput({tag, "_report_timeout"}, 32'(report_timeout), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_report_id"}, 32'(report_id), 32'd0);
    checkOutput({tag, "_token_clear"}, 32'(token_clear), 32'd0);
  endtask

  task automatic doReset();
    applyStimulus('0, '0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("rst_async");
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkResetValues("rst_idle");
  endtask

  // Monitor: every accepted report entry is compared with the scoreboard head.
  always @(negedge clock) begin
    entry_t e;
    if (reset === 1'b1 && report_valid === 1'b1 && report_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_entry actual=id%0d last%0d required=none",
                 report_id, report_last);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (report_id !== e.id || report_last !== e.last) begin
          bad++;
          $display("[TB] FAIL report_entry actual=id%0d last%0d required=id%0d last%0d",
                   report_id, report_last, e.id, e.last);
        end
      end
    end
  end

  initial begin
    int  cyc;
    logic clear_seen;
    reset = 1'b0;
    applyStimulus('0, '0, 1'b0);
    $display("[TB] starting");

    // Chain 2 -> 3 -> back to origin 1, ready held high.
    doReset();
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    expectEntry(2'd1, 1'b0);
    tick();
    checkOutput("t1_origin_vec", 32'(origin_vec), 32'b0010);
    checkOutput("t1_dl_detect_any", 32'(dl_detect_any), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_origin_valid", 32'(report_valid), 32'd1);
    checkOutput("t1_origin_id", 32'(report_id), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("t1_origin_pulse_end", 32'(origin_vec), 32'd0);
    checkOutput("t1_fifo_empty", 32'(report_valid), 32'd0);
    applyStimulus(4'b0000, 4'b0100, 1'b1);
    #1;
    checkOutput("t1_no_clear", 32'(token_clear), 32'd0);
    expectEntry(2'd2, 1'b0);
    tick();
    checkOutput("t1_tok2_id", 32'(report_id), 32'd2);
    applyStimulus(4'b0010, 4'b1010, 1'b1);
    #1;
    checkOutput("t1_token_clear", 32'(token_clear), 32'd1);
    expectEntry(2'd3, 1'b1);
    tick();
    checkOutput("t1_clear_done", 32'(token_clear), 32'd0);
    checkOutput("t1_last_id", 32'(report_id), 32'd3);
    checkOutput("t1_last_flag", 32'(report_last), 32'd1);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    tick();
    checkOutput("t1_done_ignores_det", 32'(origin_vec), 32'd0);
    checkOutput("t1_drained", 32'(report_valid), 32'd0);
    checkOutput("t1_sticky_any", 32'(dl_detect_any), 32'd1);
    checkOutput("t1_no_timeout", 32'(report_timeout), 32'd0);

    // Two detectors at once, burst of three tokens, ready held low.
    doReset();
    applyStimulus(4'b1100, 4'b0000, 1'b0);
    expectEntry(2'd2, 1'b0);
    tick();
    checkOutput("t2_origin_vec", 32'(origin_vec), 32'b0100);
    applyStimulus(4'b0000, 4'b1011, 1'b0);
    expectEntry(2'd0, 1'b0);
    expectEntry(2'd1, 1'b0);
    expectEntry(2'd3, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("t2_head_held", 32'(report_id), 32'd2);
    checkOutput("t2_full_valid", 32'(report_valid), 32'd1);
    checkOutput("t2_walk_no_last", 32'(report_last), 32'd0);
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    #1;
    checkOutput("t2_token_clear", 32'(token_clear), 32'd1);
    tick();
    checkOutput("t2_done_count4_no_last", 32'(report_last), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t2_drained", 32'(report_valid), 32'd0);

    // No return token: walk must abort after TIMEOUT cycles.
    doReset();
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    expectEntry(2'd0, 1'b0);
    tick();
    cyc = 0;
    clear_seen = 1'b0;
    applyStimulus(4'b0000, 4'b0010, 1'b1);
    expectEntry(2'd1, 1'b0);
    tick();
    cyc++;
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    cyc++;
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    expectEntry(2'd2, 1'b1);
    tick();
    cyc++;
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    #1;
    clear_seen = clear_seen | token_clear;
    tick();
    cyc++;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    while (cyc < TIMEOUT - 1) begin
      clear_seen = clear_seen | token_clear;
      tick();
      cyc++;
    end
    checkOutput("t3_timeout_not_yet", 32'(report_timeout), 32'd0);
    checkOutput("t3_still_busy", 32'(busy), 32'd1);
    tick();
    cyc++;
    checkOutput("t3_timeout_set", 32'(report_timeout), 32'd1);
    checkOutput("t3_never_cleared", 32'(clear_seen), 32'd0);
    checkOutput("t3_last_id", 32'(report_id), 32'd2);
    checkOutput("t3_last_flag", 32'(report_last), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    tick();
    checkOutput("t3_drained", 32'(report_valid), 32'd0);
    checkOutput("t3_timeout_sticky", 32'(report_timeout), 32'd1);

    // Reset in the middle of a walk, then a fresh detection.
    doReset();
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    tick();
    checkOutput("t4_walk_valid", 32'(report_valid), 32'd1);
    checkOutput("t4_walk_id", 32'(report_id), 32'd3);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("t4_midwalk");
    tick();
    reset = 1'b1;
    tick();
    checkResetValues("t4_after");
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    expectEntry(2'd2, 1'b0);
    tick();
    checkOutput("t4_new_origin", 32'(origin_vec), 32'b0100);
    checkOutput("t4_new_id", 32'(report_id), 32'd2);
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    #1;
    checkOutput("t4_token_clear", 32'(token_clear), 32'd1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("t4_done_busy", 32'(busy), 32'd1);
    checkOutput("t4_drained", 32'(report_valid), 32'd0);

    // Give the monitor a bounded window to consume the scoreboard.
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
